// File: rtl/volume_agc.sv
// volume_agc: window-peak automatic gain control that steps volume's attenuation shift
//   clk_i           : clock, all state on posedge
//   reset_i         : asynchronous active-low reset
//   enable_i        : AGC enable; low returns to idle and drops any partial window
//   valid_i/sound_i : sample stream observed from volume.sound_o
//   up_o/down_o     : one-cycle step pulses (quieter / louder)
//   atten_o         : shadow of volume's 0..7 shift count
//   peak_o          : unsigned peak magnitude of the last completed window
module volume_agc #(
  parameter int                 width_p     = 24,
  parameter int                 window_lg_p = 8,
  parameter logic [width_p-1:0] hi_thresh_p = 24'h600000,
  parameter logic [width_p-1:0] lo_thresh_p = 24'h100000,
  parameter int                 holdoff_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] sound_i,
  output logic               up_o,
  output logic               down_o,
  output logic [2:0]         atten_o,
  output logic [width_p-1:0] peak_o
);
  localparam int win_n = 1 << window_lg_p;
  localparam int hold_n = holdoff_p * win_n;
  localparam int cw = $clog2((hold_n > win_n ? hold_n : win_n) + 1);
  typedef enum logic [1:0] {idle_s, measure_s, decide_s, holdoff_s} state_t;
  state_t state;
  logic [cw-1:0] cnt;
  logic [width_p-1:0] run_peak, mag, peak_nxt;
  logic last_win, last_hold, loud, quiet;
  always_comb begin
    mag = sound_i[width_p-1] ? -sound_i : sound_i;
    peak_nxt = mag > run_peak ? mag : run_peak;
    last_win = cnt == cw'(win_n - 1);
    last_hold = cnt == cw'(hold_n - 1);
    loud = run_peak > hi_thresh_p && atten_o != 3'd7;
    quiet = run_peak < lo_thresh_p && atten_o != 3'd0;
  end
  // DECIDE completes even if enable drops that cycle, so a pulse and its
  // atten_o update are never split and the shadow stays in step with volume.
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= idle_s;
      cnt <= '0;
      run_peak <= '0;
      up_o <= 1'b0;
      down_o <= 1'b0;
      atten_o <= '0;
      peak_o <= '0;
    end else begin
      up_o <= 1'b0;
      down_o <= 1'b0;
      if (state == decide_s) begin
        peak_o <= run_peak;
        run_peak <= '0;
        up_o <= loud;
        down_o <= !loud && quiet;
        atten_o <= loud ? atten_o + 3'd1 : quiet ? atten_o - 3'd1 : atten_o;
        state <= !enable_i ? idle_s : (loud || quiet) && hold_n != 0 ? holdoff_s : measure_s;
      end else if (!enable_i) begin
        state <= idle_s;
        cnt <= '0;
        run_peak <= '0;
      end else if (state == idle_s)
        state <= measure_s;
      else if (valid_i && state == measure_s) begin
        run_peak <= peak_nxt;
        cnt <= last_win ? '0 : cnt + 1'b1;
        state <= last_win ? decide_s : measure_s;
      end else if (valid_i) begin
        cnt <= last_hold ? '0 : cnt + 1'b1;
        state <= last_hold ? measure_s : holdoff_s;
      end
    end
endmodule
